// File: rtl/demux_deser2.sv
// demux_deser2: two-channel bit deserializer behind a 1:2 demux, with per-channel word buffers
// and a round-robin valid/ready output port.
module demux_deser2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         s,
  input  logic [1:0]   y,
  input  logic         bit_vld,
  input  logic         clr,
  output logic [W-1:0] out_data,
  output logic         out_ch,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   ovf
);
  localparam int CW = $clog2(W);
  logic [CW-1:0] cnt [2];
  logic [W-1:0]  sr [2];
  logic [W-1:0]  hold [2];
  logic [W-1:0]  nsr [2];
  logic [1:0]    pend, hit, done, pop;
  logic          rr, take, free, load, sel;
  assign take = bit_vld & en;
  assign free = !out_valid | out_ready;
  assign sel  = &pend ? rr : pend[1];
  assign load = free & |pend;
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      nsr[i]  = {sr[i][W-2:0], y[i]};
      hit[i]  = take & (s == 1'(i));
      done[i] = hit[i] & (cnt[i] == CW'(W - 1));
      pop[i]  = load & (sel == 1'(i));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i]  <= '0;
        sr[i]   <= '0;
        hold[i] <= '0;
      end
      pend <= '0;
      ovf  <= '0;
    end else if (clr) begin
      for (int i = 0; i < 2; i++) begin
        cnt[i]  <= '0;
        sr[i]   <= '0;
        hold[i] <= '0;
      end
      pend <= '0;
      ovf  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (hit[i]) begin
          sr[i]  <= nsr[i];
          cnt[i] <= done[i] ? '0 : cnt[i] + CW'(1);
        end
        // a pop in the same cycle frees the slot, so the new word replaces it
        if (done[i] & (!pend[i] | pop[i])) hold[i] <= nsr[i];
        pend[i] <= done[i] | (pend[i] & !pop[i]);
        ovf[i]  <= ovf[i] | (done[i] & pend[i] & !pop[i]);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= 1'b0;
      out_valid <= 1'b0;
      rr        <= 1'b0;
    end else if (clr) begin
      out_data  <= '0;
      out_ch    <= 1'b0;
      out_valid <= 1'b0;
      rr        <= 1'b0;
    end else if (load) begin
      out_data  <= hold[sel];
      out_ch    <= sel;
      out_valid <= 1'b1;
      rr        <= ~sel;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_demux_deser2.sv
// tb_demux_deser2: directed and random stimulus checked every cycle against an event-level model.
module tb_demux_deser2;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, en = 0, s = 0, bit_vld = 0, clr = 0, out_ready = 0;
  logic [1:0] y = 0;
  logic [W-1:0] out_data;
  logic out_ch, out_valid;
  logic [1:0] ovf;
  int n_chk = 0, n_err = 0;

  demux_deser2 #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .y(y), .bit_vld(bit_vld), .clr(clr),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Model: integer word accumulation, a one-word slot per channel and an output slot.
  int m_bits [2], m_acc [2], m_hold [2], m_data;
  bit m_pend [2], m_ovf [2], m_valid, m_ch, m_rr;

  always @(posedge clk or negedge rst_n) begin
    int svc, c, w;
    bit complete;
    if (!rst_n || clr) begin
      for (int i = 0; i < 2; i++) begin
        m_bits[i] = 0; m_acc[i] = 0; m_hold[i] = 0; m_pend[i] = 0; m_ovf[i] = 0;
      end
      m_data = 0; m_valid = 0; m_ch = 0; m_rr = 0;
    end else begin
      complete = 0; c = 0; w = 0;
      if (bit_vld && en) begin
        c = s;
        m_acc[c] = (m_acc[c] * 2 + y[c]) % (1 << W);
        m_bits[c]++;
        if (m_bits[c] == W) begin
          m_bits[c] = 0;
          complete = 1;
          w = m_acc[c];
        end
      end
      svc = -1;
      if (!m_valid || out_ready) begin
        if (m_pend[0] && m_pend[1]) svc = m_rr;
        else if (m_pend[0]) svc = 0;
        else if (m_pend[1]) svc = 1;
        if (svc >= 0) begin
          m_data = m_hold[svc]; m_ch = svc[0]; m_valid = 1; m_pend[svc] = 0; m_rr = !svc[0];
        end else m_valid = 0;
      end
      if (complete) begin
        if (m_pend[c]) m_ovf[c] = 1;
        else begin
          m_hold[c] = w; m_pend[c] = 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_valid", {31'b0, out_valid}, {31'b0, m_valid});
      chk("model_ovf", {30'b0, ovf}, {30'b0, m_ovf[1], m_ovf[0]});
      if (m_valid) begin
        chk("model_data", {24'b0, out_data}, m_data);
        chk("model_ch", {31'b0, out_ch}, {31'b0, m_ch});
      end
    end
  end

  task automatic cycle(input logic e, input logic ch, input logic b, input logic v);
    en = e; s = ch; y = 2'($urandom); y[ch] = b; bit_vld = v;
    @(posedge clk); #2;
  endtask

  task automatic send_word(input logic ch, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) cycle(1, ch, w[i], 1);
  endtask

  task automatic send_pair(input logic [W-1:0] w0, input logic [W-1:0] w1);
    for (int i = W - 1; i >= 0; i--) begin
      cycle(1, 0, w0[i], 1);
      cycle(1, 1, w1[i], 1);
    end
  endtask

  task automatic do_clr;
    clr = 1; cycle(0, 0, 0, 0); clr = 0;
  endtask

  initial begin
    logic [W-1:0] d0;
    #12;
    chk("reset_valid", {31'b0, out_valid}, 0);
    chk("reset_data", {24'b0, out_data}, 0);
    chk("reset_ch", {31'b0, out_ch}, 0);
    chk("reset_ovf", {30'b0, ovf}, 0);
    rst_n = 1;
    @(posedge clk); #2;
    out_ready = 1;
    send_word(0, 8'hB2);
    cycle(0, 0, 0, 0);
    chk("single_valid", {31'b0, out_valid}, 1);
    chk("single_data", {24'b0, out_data}, 32'hB2);
    chk("single_ch", {31'b0, out_ch}, 0);
    cycle(0, 0, 0, 0);
    chk("single_pulse", {31'b0, out_valid}, 0);
    chk("single_ovf", {30'b0, ovf}, 0);

    send_pair(8'hA5, 8'h3C);
    chk("ilv_first_data", {24'b0, out_data}, 32'hA5);
    chk("ilv_first_ch", {31'b0, out_ch}, 0);
    cycle(0, 0, 0, 0);
    chk("ilv_second_data", {24'b0, out_data}, 32'h3C);
    chk("ilv_second_ch", {31'b0, out_ch}, 1);
    cycle(0, 0, 0, 0);

    out_ready = 0;
    send_pair(8'h5A, 8'hC3);
    d0 = out_data;
    chk("cont_ch", {31'b0, out_ch}, 0);
    chk("cont_data", {24'b0, d0}, 32'h5A);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0);
      chk("cont_stall_valid", {31'b0, out_valid}, 1);
      chk("cont_stall_data", {24'b0, out_data}, {24'b0, d0});
    end
    out_ready = 1;
    cycle(0, 0, 0, 0);
    chk("cont_next_ch", {31'b0, out_ch}, 1);
    chk("cont_next_data", {24'b0, out_data}, 32'hC3);
    cycle(0, 0, 0, 0);
    chk("cont_drained", {31'b0, out_valid}, 0);

    out_ready = 0;
    send_word(1, 8'h11);
    send_word(1, 8'h22);
    send_word(1, 8'h33);
    chk("ovf_flag", {30'b0, ovf}, 32'h2);
    chk("ovf_out", {24'b0, out_data}, 32'h11);
    out_ready = 1;
    cycle(0, 0, 0, 0);
    chk("ovf_hold_next", {24'b0, out_data}, 32'h22);
    cycle(0, 0, 0, 0);
    chk("ovf_dropped", {31'b0, out_valid}, 0);
    chk("ovf_sticky", {30'b0, ovf}, 32'h2);
    do_clr;
    chk("ovf_clr", {30'b0, ovf}, 0);

    for (int i = W - 1; i >= 4; i--) cycle(1, 0, i[0] ^ 1'b1, 1);
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 1);
    for (int i = 3; i >= 0; i--) cycle(1, 0, i[0] ^ 1'b1, 1);
    cycle(0, 0, 0, 0);
    chk("gap_data", {24'b0, out_data}, 32'h55);
    chk("gap_valid", {31'b0, out_valid}, 1);
    cycle(0, 0, 0, 0);

    for (int i = 0; i < 4; i++) cycle(1, 0, 1, 1);
    #1 rst_n = 0;
    #2 rst_n = 1;
    send_word(0, 8'h69);
    cycle(0, 0, 0, 0);
    chk("rst_mid_data", {24'b0, out_data}, 32'h69);
    chk("rst_mid_valid", {31'b0, out_valid}, 1);
    cycle(0, 0, 0, 0);
    chk("rst_mid_single", {31'b0, out_valid}, 0);

    for (int i = 0; i < 4000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 299) == 0);
      cycle($urandom_range(0, 7) != 0, 1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);
      clr = 0;
      if (i == 2500) begin
        #1 rst_n = 0;
        #2 rst_n = 1;
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/demux_deser2.md
# demux_deser2

Dual-channel deserializer placed directly downstream of the 1:2 bit demultiplexer. It samples the demux outputs `y[1:0]` on a bit strobe and shifts each channel's bits into its own W-bit word. It buffers completed words per channel and presents them on a single valid/ready output port tagged with the channel number, arbitrating round-robin between the two channels.

## Interface
- `W`, default 8: word width in bits; must be at least 2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  demux enable, tapped from the same net that drives the demux.
- `s`  in  1  demux select, tapped; selects the channel being received.
- `y`  in  2  demux outputs.
- `bit_vld`  in  1  strobe: one new bit is present this cycle.
- `clr`  in  1  synchronous clear of all state.
- `out_data`  out  W  completed word; MSB is the first bit received.
- `out_ch`  out  1  channel the word came from.
- `out_valid`  out  1  `out_data` and `out_ch` are valid.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `ovf`  out  2  sticky per-channel overflow flags.

## Operation
- **Sample condition:** `take = bit_vld & en`. On `take`, the channel is `c = s` and the bit is `y[c]`.
  - `sr[c] <= {sr[c][W-2:0], y[c]}`
  - `cnt[c]` increments.
  - The other channel's `sr` and `cnt` hold.
- **Bit counter:** `cnt[c]` is $clog2(W) bits wide. When `take` arrives with `cnt[c] == W-1`, the word completes:
  - `cnt[c] <= 0`
  - `hold[c] <= {sr[c][W-2:0], y[c]}`
  - `pend[c] <= 1`
- **Disable:** with `en = 0`, bits are ignored. Partial counts and shift contents are retained, and a word resumes when `en` returns.
- **Output register:** `out_data`, `out_ch` and `out_valid` are registered.
  - The register is free when `!out_valid` or when `(out_valid & out_ready)`.
  - When it is free and any `pend` is set, one channel is loaded, its `pend` is cleared, and `out_valid` is set.
  - When it is free and no `pend` is set, `out_valid` goes to 0.
- **Round-robin arbitration:** uses a 1-bit pointer `rr` that names the priority channel.
  - If both channels are pending, channel `rr` is served and `rr` becomes the other channel.
  - If only one channel is pending, that channel is served and `rr` becomes the other channel.
- **Overflow:** a word completes for channel `c` while `pend[c] = 1`, and `hold[c]` is not moved to the output register in that same cycle.
  - The new word is dropped and `hold[c]` is unchanged.
  - `ovf[c]` is set and stays set until reset or `clr`.
  - If `hold[c]` moves out in the same cycle, the new word loads normally and no overflow is flagged.
- **Clear:** `clr = 1` zeroes `cnt`, `sr`, `hold`, `pend`, `ovf`, `out_valid`, `out_data`, `out_ch` and `rr`. `clr` has priority over `take` and the handshake.
- **Reset:** every register, including `rr`, is set to 0, so channel 0 has first priority. This applies immediately on `rst_n` low, including in the middle of a word or handshake. An in-flight word is discarded.

## Timing
- **Latency:** the last bit is sampled at edge N, `hold[c]`/`pend[c]` are updated at N, and `out_valid` rises at N+1 if the output register is free.
- **Stall:** while `out_valid & !out_ready`, `out_data` and `out_ch` are stable.
- **Throughput:** one word per cycle at the output. With `out_ready` held at 1, back-to-back pending words are presented on consecutive cycles.
- **Buffering:** per channel, storage is one word in `hold` plus the shared output register. A channel overflows only when its `hold` is full and the output register keeps serving the other channel or remains stalled.
- **Simultaneous events:**
  - A completing word and a pop of the same `hold` in the same cycle replace the stored word.
  - `take` and an output handshake proceed independently in the same cycle.
- **Reset values:** `out_valid = 0`, `out_data = 0`, `out_ch = 0`, `ovf = 2'b00`.

## Test plan
- **Single word, ch0:** W=8, `en=1`, `s=0`, `out_ready=1`, bits 1,0,1,1,0,0,1,0 on consecutive `bit_vld` cycles. Expect `out_data=8'hB2`, `out_ch=0` and `out_valid=1` for exactly one cycle, 1 cycle after the 8th sample edge; `ovf=0`.
- **Interleaved channels:** alternate `s` each bit, sending 8'hA5 on ch0 and 8'h3C on ch1. Expect both words intact and unaffected by the interleaving; ch0's word appears first.
- **Contention and round-robin:** `out_ready=0`, one word completed on each channel.
  - Expect `out_valid=1`, `out_ch=0`, and data stable across 5 stall cycles.
  - After `out_ready` rises, expect ch0 then ch1 on the next cycle; `rr` is then 0.
- **Overflow:** `out_ready=0`, three words on ch1 (8'h11, 8'h22, 8'h33). Expect `ovf=2'b10`; the output holds 8'h11, and `hold[1]` holds 8'h22 and is presented next. 8'h33 is dropped. `ovf` stays set until `clr`, which returns it to 2'b00.
- **Enable gap / reset mid-word:**
  - 4 bits sent, `en=0` with `bit_vld` toggling for 3 cycles, then 4 more bits. Expect a single word from the 8 enabled bits.
  - Repeat, but pulse `rst_n` low after 4 bits. The old partial word is discarded, and the next 8 bits form a clean word.
